reg_dump: RTL
=============

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 The block SHALL have one parameter: LAST_REG, default 7, highest register index dumped (legal 0..7); registers 0..LAST_REG are dumped in ascending order.
REQ-002 The block SHALL have the following ports, one per line: name  direction  width  meaning.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request a dump; sampled only in IDLE.
REQ-006 Abort  input  1  synchronous cancel of a dump in progress.
REQ-007 SR_SEL  output  3  register-file read address, wired to a register-file source-select port.
REQ-008 SR_DATA  input  16  register-file read data for SR_SEL; combinational, valid within the same cycle.
REQ-009 OUT_DATA  output  16  captured register value.
REQ-010 OUT_IDX  output  3  index of the register held in OUT_DATA.
REQ-011 OUT_VALID  output  1  OUT_DATA/OUT_IDX valid to the consumer.
REQ-012 OUT_READY  input  1  consumer accepts the word when high with OUT_VALID.
REQ-013 BUSY  output  1  high in every state except IDLE.
REQ-014 DONE  output  1  one-cycle pulse after the final word is accepted.
REQ-015 CHECKSUM  output  16  modulo-2^16 sum of all words accepted in the current dump.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SEL, SEND, FIN.
REQ-017 IDLE: Start=1 and Abort=0 at an edge -> SEL, with the index counter set to 0 and CHECKSUM cleared to 0; otherwise remain in IDLE.
REQ-018 SEL: SR_SEL SHALL equal the index counter; at the next edge, SR_DATA is latched into OUT_DATA, the index into OUT_IDX, and OUT_VALID is set -> SEND.
REQ-019 SEND: OUT_VALID=1; OUT_DATA and OUT_IDX SHALL hold stable until OUT_VALID and OUT_READY are both high at an edge.
REQ-020 On acceptance in SEND, CHECKSUM SHALL become CHECKSUM+OUT_DATA, truncated to 16 bits, and OUT_VALID SHALL clear at that edge.
REQ-021 On acceptance, if index = LAST_REG -> FIN; otherwise index increments by 1 -> SEL.
REQ-022 FIN: DONE=1 for exactly this one cycle -> IDLE unconditionally.
REQ-023 Latency: Start sampled at edge k -> OUT_VALID high after edge k+1; with OUT_READY tied high, each word occupies 2 cycles, and DONE is high in the cycle after edge k+2*(LAST_REG+1).
REQ-024 Start SHALL be ignored while BUSY=1; no queuing, no restart.
REQ-025 Abort=1 at an edge in SEL, SEND or FIN -> IDLE with OUT_VALID=0 and DONE=0; CHECKSUM holds its partial value; Abort has priority over acceptance in the same cycle.
REQ-026 Start and Abort both high in IDLE -> remain in IDLE.
REQ-027 SR_SEL SHALL hold its last value outside SEL; OUT_DATA, OUT_IDX and CHECKSUM SHALL hold between dumps.
REQ-028 LAST_REG=0 -> a single word (R0) is dumped, then FIN.
REQ-029 SR_DATA SHALL be sampled only at the edge that ends SEL; register-file writes after that edge do not alter OUT_DATA.

Reset
REQ-030 Reset=0 SHALL immediately force IDLE, SR_SEL=0, OUT_DATA=0, OUT_IDX=0, OUT_VALID=0, BUSY=0, DONE=0, CHECKSUM=0, and index=0, independent of Clk.
REQ-031 Reset asserted mid-dump SHALL abandon the dump; after release, no word or DONE is emitted until a new Start.
REQ-032 The first active edge after Reset releases SHALL be evaluated as IDLE.

Verification
REQ-033 R0..R7 = 0x0001..0x0008, LAST_REG=7, OUT_READY=1, pulse Start -> eight words with OUT_IDX 0..7, DONE 17 cycles after the Start edge, CHECKSUM=0x0024.
REQ-034 R3=0xFFFF, R4=0x0002, all others 0 -> CHECKSUM=0x0001 (wrap-around).
REQ-035 OUT_READY held low for 5 cycles on word 2 -> OUT_VALID stays high, OUT_DATA/OUT_IDX stable, no index advance; dump resumes when OUT_READY=1.
REQ-036 Abort asserted while OUT_IDX=3 with OUT_READY=1 in the same cycle -> IDLE, no DONE, CHECKSUM = sum of R0..R2 only.
REQ-037 Start re-pulsed mid-dump -> ignored, word order unchanged; Reset=0 asynchronously mid-SEND -> all outputs 0 immediately, no further words after release.
REQ-038 LAST_REG=0, Start -> a single word R0, then DONE pulse; BUSY high for exactly 3 cycles.

Source files
------------

// File: rtl/reg_dump.sv
// Register-file dumper: walks registers 0..LAST_REG, presents each over a
// valid/ready handshake and keeps a running 16-bit checksum of accepted words.
module reg_dump #(
    parameter int unsigned LAST_REG = 7
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Abort,
    output logic [2:0]  SR_SEL,
    input  logic [15:0] SR_DATA,
    output logic [15:0] OUT_DATA,
    output logic [2:0]  OUT_IDX,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] CHECKSUM
);

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        SEND,
        FIN
    } state_t;

    localparam logic [2:0] LastIdx = 3'(LAST_REG);

    state_t      state_q, state_d;
    logic [2:0]  index_q, index_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] sum_q, sum_d;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            index_q <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
        end
    end

    // Abort is tested before the handshake so it wins over an acceptance in the same cycle.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        data_d  = data_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        case (state_q)
            IDLE: begin
                if (Start && !Abort) begin
                    state_d = SEL;
                    index_d = '0;
                    sum_d   = '0;
                end
            end
            SEL: begin
                if (Abort) begin
                    state_d = IDLE;
                end else begin
                    data_d  = SR_DATA;
                    idx_d   = index_q;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (Abort) begin
                    state_d = IDLE;
                end else if (OUT_READY) begin
                    sum_d = sum_q + data_q;
                    if (index_q == LastIdx) begin
                        state_d = FIN;
                    end else begin
                        index_d = index_q + 3'd1;
                        state_d = SEL;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The index only moves on entry to SEL, so it doubles as the held read address.
    assign SR_SEL    = index_q;
    assign OUT_DATA  = data_q;
    assign OUT_IDX   = idx_q;
    assign OUT_VALID = (state_q == SEND);
    assign BUSY      = (state_q != IDLE);
    assign DONE      = (state_q == FIN);
    assign CHECKSUM  = sum_q;

endmodule
